ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter that shares the single program/data RAM between the CPU controller and the program loader, the serial/debug path that writes programs into RAM. It sits between both requesters and the RAM macro. It serialises their accesses with a request/grant handshake, uses round-robin fairness, and gives the loader an optional lock that shuts the CPU out during programming.

## Interface
- ADDR_W, 4, RAM address width (16 words).
- DATA_W, 8, RAM data width (matches the shared bus).

Ports:
- i_clk  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_cpu_req  in  1  CPU access request; held until o_cpu_gnt
- i_cpu_we  in  1  CPU access is a write (1) or read (0)
- i_cpu_addr  in  ADDR_W  CPU address
- i_cpu_wdata  in  DATA_W  CPU write data
- o_cpu_gnt  out  1  one-cycle pulse in the cycle the CPU access is issued
- o_cpu_rvalid  out  1  one-cycle pulse; o_rdata holds the CPU read result
- i_ld_req, i_ld_we, i_ld_addr, i_ld_wdata  in  1/1/ADDR_W/DATA_W  loader request fields, with the same rules as the CPU
- i_ld_lock  in  1  while high, CPU requests are never granted
- o_ld_gnt  out  1  loader grant pulse
- o_ld_rvalid  out  1  loader read-data valid pulse
- o_rdata  out  DATA_W  read data, shared by both ports (passthrough of i_ram_rdata)
- o_ram_addr  out  ADDR_W  RAM address
- o_ram_we  out  1  RAM write enable, active-high
- o_ram_wdata  out  DATA_W  RAM write data
- i_ram_rdata  in  DATA_W  RAM read data; synchronous RAM with 1-cycle read latency
- o_busy  out  1  high in the ISSUE state

## Operation
- FSM with two states, IDLE and ISSUE. Reset state is IDLE.
- IDLE:
  - If no eligible request, stay in IDLE.
  - Otherwise pick a winner and capture its we/addr/wdata into a request register. Go to ISSUE.
  - Eligible means: CPU = i_cpu_req && !i_ld_lock; loader = i_ld_req.
- ISSUE:
  - Drive o_ram_* from the request register.
  - Pulse the winner's gnt.
  - Update last_winner. Return to IDLE.
  - Requests are not sampled in ISSUE.
- Arbitration:
  - If only one requester is eligible, it wins.
  - If both are eligible, the requester that is not last_winner wins.
  - last_winner resets to LOADER, so the CPU wins the first tie.
- Reads:
  - The cycle after ISSUE, pulse the winner's rvalid.
  - o_rdata = i_ram_rdata at all times.
  - The response cycle overlaps the next IDLE arbitration.
- Writes: no rvalid pulse.
- Requester rule: deassert req, or present a new access, in the cycle after gnt. If req is still high in IDLE, it is treated as a new access.
- i_ld_lock:
  - Sampled only in IDLE.
  - Asserting it during a CPU ISSUE does not abort that access.
  - A locked CPU request waits; it is not dropped.
- When not in ISSUE: o_ram_we = 0; o_ram_addr and o_ram_wdata hold their last values.

## Timing
- Reset values of all outputs are 0: gnts, rvalids, o_ram_we, o_ram_addr, o_ram_wdata, o_busy. o_rdata follows i_ram_rdata.
- Reset mid-ISSUE:
  - o_ram_we drops asynchronously.
  - The pending access and its rvalid are discarded; no gnt or rvalid appears after reset.
- Latency, request sampled in IDLE at cycle N:
  - gnt and RAM strobe in N+1.
  - rvalid and data in N+2.
- Throughput: one access per 2 cycles. Continuous contention alternates CPU, LD, CPU, LD.
- Worst-case CPU wait with the lock low: 4 cycles from request to gnt.
- Simultaneous events:
  - A request arriving during ISSUE is arbitrated at the next IDLE.
  - rvalid of access k and gnt of access k+1 never overlap; rvalid is in IDLE.

## Structure
- Shared package cpu_pkg holds:
  - ADDR_W and DATA_W defaults
  - state encoding ST_IDLE/ST_ISSUE
  - requester IDs REQ_CPU=0, REQ_LD=1
- The round-robin picker is a natural sub-module, rr_pick2. Inputs: eligible[1:0], last_winner. Output: winner. It is purely combinational.
- Everything else stays in ram_arbiter: FSM, request register, rvalid flag and owner.
- Estimated size: about 150 lines.

## Test plan
- CPU-only read, with RAM[3]=8'hA5: CPU requests addr 3 at cycle 0. Expect o_cpu_gnt at 1 with o_ram_addr=3 and o_ram_we=0, then o_cpu_rvalid at 2 with o_rdata=8'hA5.
- Loader write then CPU read: LD writes addr 7 = 8'h3C, then CPU reads 7. Expect o_ram_we=1 only in the LD ISSUE cycle, and o_cpu_rvalid with o_rdata=8'h3C.
- Tie after reset: both request continuously for 6 accesses. Expect grant order CPU, LD, CPU, LD, CPU, LD, with gnts 2 cycles apart and no dual gnt.
- Lock:
  - i_ld_lock=1 with both requesting: only LD is granted while locked.
  - The CPU request is held throughout.
  - The CPU is granted 2 cycles after the lock drops.
- Reset mid-write: assert i_reset during a CPU write ISSUE cycle. Expect o_ram_we=0 immediately, RAM unchanged at the next cycle, and no rvalid; after release the FSM is in IDLE.
- Back-to-back same requester: CPU keeps req high for reads of addr 0, 1, 2. Expect gnts at cycles 1, 3, 5 and rvalids at 2, 4, 6 with the matching data.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared widths, FSM encoding and requester IDs for the RAM arbiter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int unsigned RAM_ADDR_W = 4;
    localparam int unsigned RAM_DATA_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } arb_state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_LD  = 1'b1
    } req_id_e;

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// ============================================================================
// Module   : rr_pick2
// Brief    : Two-way round-robin picker; on a tie the non-last winner wins
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick2
    import cpu_pkg::*;
(
    input  logic [1:0] eligible_i,
    input  req_id_e    last_winner_i,
    output req_id_e    winner_o
);

    // Bit 0 is the CPU, bit 1 the loader.
    always_comb begin
        winner_o = REQ_CPU;
        case (eligible_i)
            2'b01:   winner_o = REQ_CPU;
            2'b10:   winner_o = REQ_LD;
            2'b11:   winner_o = (last_winner_i == REQ_CPU) ? REQ_LD : REQ_CPU;
            default: winner_o = REQ_CPU;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// Module   : ram_arbiter
// Brief    : Shares one synchronous RAM between the CPU and the program loader
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = RAM_ADDR_W,
    parameter int unsigned DATA_W = RAM_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_gnt,
    output logic              o_cpu_rvalid,
    input  logic              i_ld_req,
    input  logic              i_ld_we,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [DATA_W-1:0] i_ld_wdata,
    input  logic              i_ld_lock,
    output logic              o_ld_gnt,
    output logic              o_ld_rvalid,
    output logic [DATA_W-1:0] o_rdata,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_we,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic              o_busy
);

    arb_state_e        state_q, state_d;
    req_id_e           owner_q, owner_d;
    req_id_e           last_winner_q, last_winner_d;
    req_id_e           rv_owner_q, rv_owner_d;
    req_id_e           winner;
    logic              req_we_q, req_we_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
    logic              rvalid_q, rvalid_d;
    logic [1:0]        eligible;

    assign eligible = {i_ld_req, i_cpu_req & ~i_ld_lock};

    rr_pick2 u_pick (
        .eligible_i    (eligible),
        .last_winner_i (last_winner_q),
        .winner_o      (winner)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            owner_q       <= REQ_CPU;
            last_winner_q <= REQ_LD;
            rv_owner_q    <= REQ_CPU;
            req_we_q      <= 1'b0;
            req_addr_q    <= '0;
            req_wdata_q   <= '0;
            rvalid_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_winner_q <= last_winner_d;
            rv_owner_q    <= rv_owner_d;
            req_we_q      <= req_we_d;
            req_addr_q    <= req_addr_d;
            req_wdata_q   <= req_wdata_d;
            rvalid_q      <= rvalid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_winner_d = last_winner_q;
        rv_owner_d    = rv_owner_q;
        req_we_d      = req_we_q;
        req_addr_d    = req_addr_q;
        req_wdata_d   = req_wdata_q;
        rvalid_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    state_d = ST_ISSUE;
                    owner_d = winner;
                    if (winner == REQ_CPU) begin
                        req_we_d    = i_cpu_we;
                        req_addr_d  = i_cpu_addr;
                        req_wdata_d = i_cpu_wdata;
                    end else begin
                        req_we_d    = i_ld_we;
                        req_addr_d  = i_ld_addr;
                        req_wdata_d = i_ld_wdata;
                    end
                end
            end
            ST_ISSUE: begin
                state_d       = ST_IDLE;
                last_winner_d = owner_q;
                rvalid_d      = ~req_we_q;
                rv_owner_d    = owner_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Address/data registers only change on entry to ISSUE, so they hold in IDLE.
    assign o_busy       = (state_q == ST_ISSUE);
    assign o_cpu_gnt    = o_busy && (owner_q == REQ_CPU);
    assign o_ld_gnt     = o_busy && (owner_q == REQ_LD);
    assign o_ram_we     = o_busy && req_we_q;
    assign o_ram_addr   = req_addr_q;
    assign o_ram_wdata  = req_wdata_q;
    assign o_cpu_rvalid = rvalid_q && (rv_owner_q == REQ_CPU);
    assign o_ld_rvalid  = rvalid_q && (rv_owner_q == REQ_LD);
    assign o_rdata      = i_ram_rdata;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// Module   : tb_ram_arbiter
// Brief    : Directed self-checking bench for ram_arbiter with a 16x8 RAM model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_cpu_req, i_cpu_we, i_ld_req, i_ld_we, i_ld_lock;
    logic [3:0] i_cpu_addr, i_ld_addr;
    logic [7:0] i_cpu_wdata, i_ld_wdata;
    logic       o_cpu_gnt, o_cpu_rvalid, o_ld_gnt, o_ld_rvalid, o_ram_we, o_busy;
    logic [7:0] o_rdata, o_ram_wdata, i_ram_rdata;
    logic [3:0] o_ram_addr;

    logic [7:0] mem [16];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 i_clk = ~i_clk;

    // Synchronous RAM, one-cycle read latency.
    always @(posedge i_clk) begin
        if (o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
        i_ram_rdata <= mem[o_ram_addr];
    end

    ram_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_cpu_req    (i_cpu_req),
        .i_cpu_we     (i_cpu_we),
        .i_cpu_addr   (i_cpu_addr),
        .i_cpu_wdata  (i_cpu_wdata),
        .o_cpu_gnt    (o_cpu_gnt),
        .o_cpu_rvalid (o_cpu_rvalid),
        .i_ld_req     (i_ld_req),
        .i_ld_we      (i_ld_we),
        .i_ld_addr    (i_ld_addr),
        .i_ld_wdata   (i_ld_wdata),
        .i_ld_lock    (i_ld_lock),
        .o_ld_gnt     (o_ld_gnt),
        .o_ld_rvalid  (o_ld_rvalid),
        .o_rdata      (o_rdata),
        .o_ram_addr   (o_ram_addr),
        .o_ram_we     (o_ram_we),
        .o_ram_wdata  (o_ram_wdata),
        .i_ram_rdata  (i_ram_rdata),
        .o_busy       (o_busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        step();
        step();
        i_reset = 1'b0;
    endtask

    // Per-cycle {ld_gnt,cpu_gnt} expectations.
    logic [1:0] tie_gnt  [12] = '{2'b01,2'b00,2'b10,2'b00,2'b01,2'b00,
                                  2'b10,2'b00,2'b01,2'b00,2'b10,2'b00};
    logic [1:0] tie_rv   [12] = '{2'b00,2'b01,2'b00,2'b10,2'b00,2'b01,
                                  2'b00,2'b10,2'b00,2'b01,2'b00,2'b10};
    logic [1:0] lock_gnt [8]  = '{2'b10,2'b00,2'b10,2'b00,2'b10,2'b00,2'b01,2'b00};

    initial begin
        i_reset = 1'b1;
        {i_cpu_req, i_cpu_we, i_ld_req, i_ld_we, i_ld_lock} = '0;
        i_cpu_addr = '0; i_ld_addr = '0; i_cpu_wdata = '0; i_ld_wdata = '0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'hA5;
        step();
        step();
        check_val("rst_gnt",    {o_ld_gnt, o_cpu_gnt}, 2'b00);
        check_val("rst_rvalid", {o_ld_rvalid, o_cpu_rvalid}, 2'b00);
        check_val("rst_ram",    {o_ram_we, o_ram_addr, o_ram_wdata}, 13'h0);
        check_val("rst_busy",   o_busy, 1'b0);
        i_reset = 1'b0;

        // CPU-only read of addr 3
        i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 4'd3;
        step();
        check_val("rd_gnt",  {o_ld_gnt, o_cpu_gnt, o_busy}, 3'b011);
        check_val("rd_ram",  {o_ram_we, o_ram_addr}, {1'b0, 4'd3});
        i_cpu_req = 1'b0;
        step();
        check_val("rd_rvalid", {o_ld_rvalid, o_cpu_rvalid, o_cpu_gnt}, 3'b010);
        check_val("rd_data",   o_rdata, 8'hA5);

        // Loader write addr 7 then CPU read of addr 7
        i_ld_req = 1'b1; i_ld_we = 1'b1; i_ld_addr = 4'd7; i_ld_wdata = 8'h3C;
        step();
        check_val("ldw_gnt", {o_ld_gnt, o_cpu_gnt}, 2'b10);
        check_val("ldw_ram", {o_ram_we, o_ram_addr, o_ram_wdata}, {1'b1, 4'd7, 8'h3C});
        i_ld_req = 1'b0; i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 4'd7;
        step();
        check_val("ldw_idle", {o_ram_we, o_ld_rvalid, o_cpu_rvalid}, 3'b000);
        step();
        check_val("cpr_gnt", {o_ld_gnt, o_cpu_gnt, o_ram_we}, 3'b010);
        i_cpu_req = 1'b0;
        step();
        check_val("cpr_rvalid", o_cpu_rvalid, 1'b1);
        check_val("cpr_data",   o_rdata, 8'h3C);

        // Tie after reset: CPU reads addr 1, LD reads addr 2
        do_reset();
        i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 4'd1;
        i_ld_req  = 1'b1; i_ld_we  = 1'b0; i_ld_addr  = 4'd2;
        for (int k = 0; k < 12; k++) begin
            step();
            check_val($sformatf("tie_gnt[%0d]", k), {o_ld_gnt, o_cpu_gnt}, tie_gnt[k]);
            check_val($sformatf("tie_rv[%0d]", k), {o_ld_rvalid, o_cpu_rvalid}, tie_rv[k]);
            if (tie_rv[k] == 2'b01) check_val($sformatf("tie_dc[%0d]", k), o_rdata, 8'h22);
            if (tie_rv[k] == 2'b10) check_val($sformatf("tie_dl[%0d]", k), o_rdata, 8'h33);
            if (k == 10) begin
                i_cpu_req = 1'b0;
                i_ld_req  = 1'b0;
            end
        end

        // Lock: CPU (addr 0) held throughout, LD reads addr 2 while locked
        i_ld_lock = 1'b1; i_cpu_req = 1'b1; i_cpu_addr = 4'd0; i_ld_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check_val($sformatf("lock_gnt[%0d]", k), {o_ld_gnt, o_cpu_gnt}, lock_gnt[k]);
            if (k == 4) begin
                i_ld_lock = 1'b0;
                i_ld_req  = 1'b0;
            end
            if (k == 6) i_cpu_req = 1'b0;
        end
        check_val("lock_rvalid", {o_cpu_rvalid, o_rdata}, {1'b1, 8'h11});

        // Reset in the middle of a CPU write ISSUE
        i_cpu_req = 1'b1; i_cpu_we = 1'b1; i_cpu_addr = 4'd5; i_cpu_wdata = 8'h5A;
        step();
        check_val("rw_we_pre", {o_cpu_gnt, o_ram_we}, 2'b11);
        #2 i_reset = 1'b1;
        #1;
        check_val("rw_async", {o_ram_we, o_cpu_gnt, o_busy}, 3'b000);
        i_cpu_req = 1'b0; i_cpu_we = 1'b0;
        step();
        check_val("rw_mem",    mem[5], 8'h00);
        check_val("rw_rvalid", {o_ld_rvalid, o_cpu_rvalid}, 2'b00);
        i_reset = 1'b0;
        step();
        check_val("rw_idle", {o_busy, o_cpu_gnt, o_ld_gnt, o_cpu_rvalid, o_ld_rvalid}, 5'b0);
        i_cpu_req = 1'b1; i_cpu_addr = 4'd5;
        step();
        check_val("rw_post_gnt", {o_cpu_gnt, o_ram_addr}, {1'b1, 4'd5});
        i_cpu_req = 1'b0;
        step();
        check_val("rw_post_rd", {o_cpu_rvalid, o_rdata}, {1'b1, 8'h00});

        // Back-to-back CPU reads of addr 0, 1, 2
        i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 4'd0;
        for (int a = 0; a < 3; a++) begin
            step();
            check_val($sformatf("b2b_gnt[%0d]", a), {o_cpu_gnt, o_ram_addr}, {1'b1, 4'(a)});
            if (a == 2) i_cpu_req = 1'b0;
            else        i_cpu_addr = 4'(a + 1);
            step();
            check_val($sformatf("b2b_rv[%0d]", a), {o_cpu_rvalid, o_cpu_gnt}, 2'b10);
            check_val($sformatf("b2b_data[%0d]", a), o_rdata, 8'h11 * (a + 1));
        end
        step();
        check_val("b2b_end", {o_busy, o_cpu_rvalid}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
